// File: rtl/act_lut_sequencer.sv
// Activation-LUT sequencer: walks a latched vector of pre-activations through one
// synchronous ROM port and a shared combinational interpolator, then pulses done.
module act_lut_sequencer #(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int FRAC = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N*W-1:0]      x_in,
    output logic                busy,
    output logic                done,
    output logic [N*W-1:0]      y_out,
    output logic [W-FRAC-1:0]   lut_addr,
    input  logic [W-1:0]        lut_data,
    output logic [W-1:0]        interp_base,
    output logic [W-1:0]        interp_next,
    output logic [W-1:0]        interp_remaining,
    input  logic [W-1:0]        interp_value
);

    localparam int A  = W - FRAC;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [A-1:0]  IDX_FLIP = A'(1) << (A - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_BASE,
        S_RD_NEXT,
        S_CAP_NEXT,
        S_WB,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [KW-1:0]   k;
    logic [N*W-1:0]  x_reg;
    logic [N*W-1:0]  y_reg;
    logic [W-1:0]    base_reg;
    logic [W-1:0]    next_reg;
    logic [W-1:0]    x_cur;
    logic [A-1:0]    cur_idx;
    logic [A-1:0]    cur_nidx;
    logic            last_elem;

    // Flipping the sign bit turns the signed integer part into an offset-binary table index.
    assign x_cur     = x_reg[k*W +: W];
    assign cur_idx   = x_cur[W-1:FRAC] ^ IDX_FLIP;
    assign cur_nidx  = (cur_idx == '1) ? cur_idx : cur_idx + A'(1);
    assign last_elem = (k == K_LAST);

    assign interp_base      = base_reg;
    assign interp_next      = next_reg;
    assign interp_remaining = {{(W-FRAC){1'b0}}, x_cur[FRAC-1:0]};
    assign y_out            = y_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (start) state_nxt = S_RD_BASE;
            S_RD_BASE:  state_nxt = S_RD_NEXT;
            S_RD_NEXT:  state_nxt = S_CAP_NEXT;
            S_CAP_NEXT: state_nxt = S_WB;
            S_WB:       state_nxt = last_elem ? S_DONE : S_RD_BASE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // ROM data always belongs to the address registered on the previous edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            k        <= '0;
            x_reg    <= '0;
            y_reg    <= '0;
            base_reg <= '0;
            next_reg <= '0;
            lut_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_reg <= x_in;
                        k     <= '0;
                    end
                end
                S_RD_BASE: begin
                    lut_addr <= cur_idx;
                end
                S_RD_NEXT: begin
                    lut_addr <= cur_nidx;
                    base_reg <= lut_data;
                end
                S_CAP_NEXT: begin
                    next_reg <= lut_data;
                end
                S_WB: begin
                    y_reg[k*W +: W] <= interp_value;
                    if (!last_elem) begin
                        k <= k + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_act_lut_sequencer.sv
// Self-checking bench for act_lut_sequencer: ROM lut[i]=4*i, behavioural interpolator,
// arithmetic reference model of the activation result per element.
module tb_act_lut_sequencer;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int FRAC = 4;
    localparam int A    = W - FRAC;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [N*W-1:0]    x_in = '0;
    logic              busy;
    logic              done;
    logic [N*W-1:0]    y_out;
    logic [A-1:0]      lut_addr;
    logic [W-1:0]      lut_data;
    logic [W-1:0]      interp_base;
    logic [W-1:0]      interp_next;
    logic [W-1:0]      interp_remaining;
    logic [W-1:0]      interp_value;

    logic [W-1:0]      rom [2**A];

    int compared   = 0;
    int mismatched = 0;

    int              done_edge;
    int              done_count;
    logic [N*W-1:0]  y_at_done;
    logic [A-1:0]    addr_log [2*N];
    logic            busy_hist [64];

    always #5 clk = ~clk;

    act_lut_sequencer #(.N(N), .W(W), .FRAC(FRAC)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .x_in             (x_in),
        .busy             (busy),
        .done             (done),
        .y_out            (y_out),
        .lut_addr         (lut_addr),
        .lut_data         (lut_data),
        .interp_base      (interp_base),
        .interp_next      (interp_next),
        .interp_remaining (interp_remaining),
        .interp_value     (interp_value)
    );

    function automatic logic [W-1:0] interp_calc(input logic [W-1:0] b, input logic [W-1:0] n,
                                                 input logic [W-1:0] r);
        int bi = $signed(b);
        int ni = $signed(n);
        int ri = int'(r);
        int p  = ((ni - bi) * ri) >>> FRAC;
        return W'(bi + p);
    endfunction

    assign lut_data     = rom[lut_addr];
    assign interp_value = interp_calc(interp_base, interp_next, interp_remaining);

    // Reference model: table position of x is (x + 2^(W-1)) / 2^FRAC in plain arithmetic.
    function automatic int m_idx(input logic [W-1:0] x);
        int xi = $signed(x);
        return (xi + 2**(W-1)) / 2**FRAC;
    endfunction

    function automatic int m_rem(input logic [W-1:0] x);
        int xi = $signed(x);
        return (xi + 2**(W-1)) % 2**FRAC;
    endfunction

    function automatic int m_nidx(input logic [W-1:0] x);
        int i = m_idx(x);
        return (i + 1 > 2**A - 1) ? i : i + 1;
    endfunction

    function automatic int m_lut(input int i);
        return 4 * i;
    endfunction

    function automatic logic [N*W-1:0] m_yvec(input logic [N*W-1:0] x);
        logic [N*W-1:0] y;
        y = '0;
        for (int j = 0; j < N; j++) begin
            int b  = m_lut(m_idx(x[j*W +: W]));
            int nx = m_lut(m_nidx(x[j*W +: W]));
            int p  = ((nx - b) * m_rem(x[j*W +: W])) >>> FRAC;
            y[j*W +: W] = W'(b + p);
        end
        return y;
    endfunction

    function automatic logic [N*W-1:0] rand_vec();
        logic [N*W-1:0] v;
        for (int j = 0; j < N; j++) v[j*W +: W] = W'($urandom());
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepting edge is edge 1; logs done, busy and ROM addresses up to edge len.
    task automatic run_vec(input logic [N*W-1:0] x, input int extra1, input int extra2, input int len);
        done_edge  = -1;
        done_count = 0;
        y_at_done  = '0;
        x_in  = x;
        start = 1'b1;
        tick();
        start = 1'b0;
        x_in  = rand_vec();
        busy_hist[1] = busy;
        for (int e = 2; e <= len; e++) begin
            start = (e == extra1) || (e == extra2);
            tick();
            start = 1'b0;
            busy_hist[e] = busy;
            if (done) begin
                done_count++;
                if (done_edge < 0) begin
                    done_edge = e;
                    y_at_done = y_out;
                end
            end
            if ((e - 2) / 4 < N) begin
                if ((e - 2) % 4 == 0) addr_log[2*((e-2)/4)]     = lut_addr;
                if ((e - 2) % 4 == 1) addr_log[2*((e-2)/4) + 1] = lut_addr;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        compared++;
        if (y_out !== '0) begin mismatched++; $display("[TB] FAIL reset_y: got %h expected 0", y_out); end
        compared++;
        if (lut_addr !== '0) begin mismatched++; $display("[TB] FAIL reset_addr: got %h expected 0", lut_addr); end
        compared++;
        if ({interp_base, interp_next, interp_remaining} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_interp: got %h %h %h expected 0", interp_base, interp_next, interp_remaining);
        end
    endtask

    task automatic test_directed();
        logic [N*W-1:0] x;
        logic [A-1:0]   exp_addr [8];
        x = 32'h807F1800;
        exp_addr = '{4'd8, 4'd9, 4'd9, 4'd10, 4'd15, 4'd15, 4'd0, 4'd1};
        run_vec(x, 0, 0, 20);
        compared++;
        if (done_edge !== 17) begin mismatched++; $display("[TB] FAIL directed_done_edge: got %0d expected 17", done_edge); end
        compared++;
        if (done_count !== 1) begin mismatched++; $display("[TB] FAIL directed_done_count: got %0d expected 1", done_count); end
        compared++;
        if (y_at_done !== 32'h003C2620) begin mismatched++; $display("[TB] FAIL directed_y: got %h expected 003c2620", y_at_done); end
        compared++;
        if (y_at_done !== m_yvec(x)) begin mismatched++; $display("[TB] FAIL directed_y_model: got %h expected %h", y_at_done, m_yvec(x)); end
        for (int i = 0; i < 2*N; i++) begin
            compared++;
            if (addr_log[i] !== exp_addr[i]) begin
                mismatched++;
                $display("[TB] FAIL directed_addr[%0d]: got %0d expected %0d", i, addr_log[i], exp_addr[i]);
            end
        end
        for (int e = 1; e <= 20; e++) begin
            compared++;
            if (busy_hist[e] !== (e <= 17)) begin
                mismatched++;
                $display("[TB] FAIL directed_busy@%0d: got %b expected %b", e, busy_hist[e], (e <= 17));
            end
        end
        compared++;
        if (y_out !== 32'h003C2620) begin mismatched++; $display("[TB] FAIL directed_y_hold: got %h expected 003c2620", y_out); end
    endtask

    task automatic test_all_negative();
        run_vec({N{8'hF8}}, 0, 0, 18);
        compared++;
        if (y_at_done !== 32'h1E1E1E1E) begin mismatched++; $display("[TB] FAIL neg_half_y: got %h expected 1e1e1e1e", y_at_done); end
        compared++;
        if (addr_log[0] !== 4'd7 || addr_log[1] !== 4'd8) begin
            mismatched++;
            $display("[TB] FAIL neg_half_addr: got %0d,%0d expected 7,8", addr_log[0], addr_log[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [N*W-1:0] x1;
        logic [N*W-1:0] x2;
        x1 = rand_vec();
        x2 = rand_vec();
        run_vec(x1, 3, 10, 18);
        compared++;
        if (done_edge !== 17 || done_count !== 1) begin
            mismatched++;
            $display("[TB] FAIL ignore_start_done: got edge %0d count %0d expected edge 17 count 1", done_edge, done_count);
        end
        compared++;
        if (y_at_done !== m_yvec(x1)) begin mismatched++; $display("[TB] FAIL ignore_start_y: got %h expected %h", y_at_done, m_yvec(x1)); end
        compared++;
        if (busy_hist[18] !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_idle_busy: got %b expected 0", busy_hist[18]); end
        // Accepting edge of this run is absolute edge 19, so its done lands 18 cycles after the first.
        run_vec(x2, 0, 0, 18);
        compared++;
        if (done_edge !== 17) begin mismatched++; $display("[TB] FAIL b2b_done_edge: got %0d expected 17", done_edge); end
        compared++;
        if (y_at_done !== m_yvec(x2)) begin mismatched++; $display("[TB] FAIL b2b_y: got %h expected %h", y_at_done, m_yvec(x2)); end
    endtask

    task automatic test_mid_reset();
        int dcount;
        logic [N*W-1:0] x2;
        x2 = rand_vec();
        x_in  = rand_vec();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 2; e <= 8; e++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        compared++;
        if (busy !== 1'b0 || done !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy: got busy %b done %b expected 0 0", busy, done); end
        compared++;
        if (y_out !== '0) begin mismatched++; $display("[TB] FAIL midrst_y: got %h expected 0", y_out); end
        compared++;
        if (lut_addr !== '0 || interp_base !== '0 || interp_remaining !== '0) begin
            mismatched++;
            $display("[TB] FAIL midrst_regs: got addr %h base %h rem %h expected 0", lut_addr, interp_base, interp_remaining);
        end
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done) dcount++;
        end
        compared++;
        if (dcount !== 0) begin mismatched++; $display("[TB] FAIL midrst_no_done: got %0d expected 0", dcount); end
        run_vec(x2, 0, 0, 18);
        compared++;
        if (done_edge !== 17 || y_at_done !== m_yvec(x2)) begin
            mismatched++;
            $display("[TB] FAIL midrst_restart: got edge %0d y %h expected edge 17 y %h", done_edge, y_at_done, m_yvec(x2));
        end
    endtask

    task automatic test_rst_start();
        logic [N*W-1:0] x;
        x = rand_vec();
        x_in  = rand_vec();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_start_busy: got %b expected 0", busy); end
        run_vec(x, 0, 0, 18);
        compared++;
        if (done_edge !== 17 || y_at_done !== m_yvec(x)) begin
            mismatched++;
            $display("[TB] FAIL rst_start_accept: got edge %0d y %h expected edge 17 y %h", done_edge, y_at_done, m_yvec(x));
        end
    endtask

    task automatic test_saturation();
        logic [N*W-1:0] x;
        x = {W'($urandom()), 8'h6F, 8'h70, 8'h7F};
        run_vec(x, 0, 0, 18);
        compared++;
        if (y_at_done[3*W-1:0] !== 24'h3B3C3C) begin
            mismatched++;
            $display("[TB] FAIL sat_y: got %h expected 3b3c3c", y_at_done[3*W-1:0]);
        end
        compared++;
        if (addr_log[1] !== 4'd15 || addr_log[3] !== 4'd15 || addr_log[5] !== 4'd15) begin
            mismatched++;
            $display("[TB] FAIL sat_nidx: got %0d,%0d,%0d expected 15,15,15", addr_log[1], addr_log[3], addr_log[5]);
        end
        compared++;
        if (y_at_done !== m_yvec(x)) begin mismatched++; $display("[TB] FAIL sat_y_model: got %h expected %h", y_at_done, m_yvec(x)); end
    endtask

    task automatic test_random();
        logic [N*W-1:0] x;
        for (int t = 0; t < 12; t++) begin
            x = rand_vec();
            run_vec(x, 0, 0, 18);
            compared++;
            if (done_edge !== 17 || y_at_done !== m_yvec(x)) begin
                mismatched++;
                $display("[TB] FAIL random[%0d]: x %h got edge %0d y %h expected edge 17 y %h",
                         t, x, done_edge, y_at_done, m_yvec(x));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2**A; i++) rom[i] = W'(4 * i);
        test_reset();
        test_directed();
        test_all_negative();
        test_back_to_back();
        test_mid_reset();
        test_rst_start();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
